// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode constants, fetch FSM states and reset PC.
package mips_pkg;

    localparam logic [5:0]  OP_J    = 6'h02;
    localparam logic [5:0]  OP_BEQ  = 6'h04;
    localparam logic [5:0]  OP_HALT = 6'h3F;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational redirect targets for the instruction currently returned by memory.
module fetch_target_calc (
    input  logic [31:0] inflight_pc,
    input  logic [15:0] addr16,
    input  logic [25:0] addr26,
    output logic [31:0] pc_plus4,
    output logic [31:0] jump_tgt,
    output logic [31:0] branch_tgt
);

    logic signed [31:0] br_off;

    always_comb begin
        pc_plus4   = inflight_pc + 32'd4;
        // Word offset: sign-extend the immediate, then scale to bytes.
        br_off     = {{14{addr16[15]}}, addr16, 2'b00};
        jump_tgt   = {pc_plus4[31:28], addr26, 2'b00};
        branch_tgt = pc_plus4 + $unsigned(br_off);
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch: PC ownership, j redirect, beq wait, stall replay.
// Optional halt opcode support is enabled by defining FETCH_UNIT_HALT_EN.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_addr,
    input  logic [5:0]  mem_opcode,
    input  logic [15:0] mem_addr16,
    input  logic [25:0] mem_addr26,
    input  logic        stall,
    input  logic        branch_resolve,
    input  logic        branch_taken,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic        halted
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  inflight_pc;
    logic         inflight_valid;
    logic [31:0]  branch_tgt;

    logic [31:0]  pc_plus4;
    logic [31:0]  jump_tgt_c;
    logic [31:0]  branch_tgt_c;
    logic         hold;
    logic         accept;
    logic         is_jump;
    logic         is_branch;
    logic         is_halt;

    fetch_target_calc u_target_calc (
        .inflight_pc (inflight_pc),
        .addr16      (mem_addr16),
        .addr26      (mem_addr26),
        .pc_plus4    (pc_plus4),
        .jump_tgt    (jump_tgt_c),
        .branch_tgt  (branch_tgt_c)
    );

    always_comb begin
        hold      = (state == ST_FETCH) && inflight_valid && stall;
        accept    = (state == ST_FETCH) && inflight_valid && !stall;
        is_jump   = accept && (mem_opcode == OP_J);
        is_branch = accept && (mem_opcode == OP_BEQ);
`ifdef FETCH_UNIT_HALT_EN
        is_halt   = accept && (mem_opcode == OP_HALT);
`else
        is_halt   = 1'b0;
`endif
    end

    // A stalled instruction is replayed by re-presenting its own address.
    assign pc_addr     = hold ? inflight_pc : pc;
    assign instr_valid = inflight_valid && (state != ST_HALT);
    assign instr_pc    = inflight_pc;

`ifdef FETCH_UNIT_HALT_EN
    assign halted = (state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_FETCH;
            pc             <= RESET_PC;
            inflight_pc    <= '0;
            inflight_valid <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (is_jump) begin
                        pc             <= jump_tgt_c;
                        inflight_valid <= 1'b0;
                    end else if (is_branch) begin
                        branch_tgt     <= branch_tgt_c;
                        pc             <= pc_plus4;
                        inflight_valid <= 1'b0;
                        state          <= ST_BR_WAIT;
                    end else if (is_halt) begin
                        inflight_valid <= 1'b0;
                        state          <= ST_HALT;
                    end else if (!hold) begin
                        inflight_pc    <= pc;
                        inflight_valid <= 1'b1;
                        pc             <= pc + 32'd4;
                    end
                end
                ST_BR_WAIT: begin
                    // Nothing is issued in the resolve cycle; fetch restarts next cycle.
                    if (branch_resolve) begin
                        if (branch_taken) begin
                            pc <= branch_tgt;
                        end
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end of the MIPS CPU: owns the program counter, drives the word address into the instruction memory, and consumes the decoded fields that memory returns one clock later. It tags each returned instruction with its PC and valid flag for the decode/execute stage. It redirects on `j`, stalls fetch until `beq` is resolved by execute, and replays the current fetch while downstream is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `pc_addr`  out  32  address presented to instruction memory; memory latches it on the next rising edge.
- `mem_opcode`  in  6  opcode field returned by memory.
- `mem_addr16`  in  16  immediate field returned by memory.
- `mem_addr26`  in  26  jump-index field returned by memory.
- `stall`  in  1  downstream cannot accept the current instruction.
- `branch_resolve`  in  1  execute has evaluated the pending `beq`; one-cycle pulse.
- `branch_taken`  in  1  branch outcome; sampled only when `branch_resolve` is high.
- `instr_valid`  out  1  memory fields this cycle hold a live instruction.
- `instr_pc`  out  32  PC of the instruction under `instr_valid`.
- `halted`  out  1  halt instruction retired; fetch frozen.

## Operation
- Registers: `pc` (next address to issue), `inflight_valid`, `inflight_pc`, `branch_tgt`, state.
- `instr_valid` = `inflight_valid` and state not HALT. `instr_pc` = `inflight_pc`.
- States: FETCH, BR_WAIT, HALT.
- FETCH, no stall, no control op: `pc_addr` = `pc`. At the edge, `inflight_pc` <= `pc`, `inflight_valid` <= 1, `pc` <= `pc`+4 (mod 2^32).
- Stall in FETCH with `inflight_valid`: `pc_addr` = `inflight_pc`, so memory re-latches the same word. All registers hold.
- Jump: `instr_valid`, opcode 6'h02, no stall. Target = {`inflight_pc`+4 [31:28], `mem_addr26`, 2'b00}. At the edge, `pc` <= target and `inflight_valid` <= 0, squashing the sequential fetch. Cost: one bubble.
- Branch: `instr_valid`, opcode 6'h04, no stall. `branch_tgt` <= `inflight_pc`+4 + (sign-extended `mem_addr16` << 2). `inflight_valid` <= 0; `pc` stays at `inflight_pc`+4. Go to BR_WAIT.
- BR_WAIT: `pc_addr` = `pc`, `instr_valid` = 0. On `branch_resolve`: `pc` <= `branch_taken` ? `branch_tgt` : `pc`, then go to FETCH. No issue in the resolve cycle.
- `branch_resolve` outside BR_WAIT is ignored. `stall` is ignored in BR_WAIT and HALT.
- Control-op detection is gated by `stall`: a stalled `j`/`beq` acts when `stall` drops.
- HALT: `pc_addr` holds, `instr_valid` = 0, `halted` = 1. Exit only by reset.
- Address arithmetic is 32-bit unsigned and wraps; no alignment check.

## Timing
- Fetch latency: one clock from `pc_addr` to fields. Throughput: one instruction per clock in steady state.
- Reset values: `pc_addr` = RESET_PC, `instr_valid` = 0, `instr_pc` = 0, `halted` = 0, state FETCH.
- First `instr_valid` comes in the second cycle after `reset` deasserts.
- Reset in any state, including mid BR_WAIT, discards the pending branch and takes precedence over every other event.
- Branch penalty: 1 + N cycles, where N = cycles spent waiting for `branch_resolve`.

## Configuration
- `FETCH_UNIT_HALT_EN` defined: opcode 6'h3F with `instr_valid` and no stall moves to HALT in the next cycle; that instruction is still presented as valid.
- Undefined: opcode 6'h3F is an ordinary instruction. `halted` is tied to 0.

## Structure
- Shared `mips_pkg` holds the opcode constants (OP_J = 6'h02, OP_BEQ = 6'h04, OP_HALT = 6'h3F), the fetch state enum, and the RESET_PC default.
- One sub-module, `fetch_target_calc`: combinational jump and branch target computation.

## Test plan
- Reset, then free run over 0x00..0x14 -> `pc_addr` 0,4,8,...; `instr_pc` matches one cycle later; `instr_valid` stays high.
- `j` at 0x20 with `mem_addr26` = 6 -> one bubble, next valid `instr_pc` = 0x18.
- `beq` at 0x1c with `mem_addr16` = 1, resolved taken after 3 cycles -> `instr_valid` low 4 cycles, next `instr_pc` = 0x24. Same case not taken -> next `instr_pc` = 0x20.
- `stall` held 2 cycles on 0x08 -> `pc_addr` = 0x08 both cycles, `instr_pc` = 0x08 held, no instruction skipped.
- Opcode 6'h3F at 0x24 with `FETCH_UNIT_HALT_EN` -> 0x24 presented valid, then `halted` = 1 and `pc_addr` frozen; without the macro, fetch continues at 0x28.
- Reset asserted during BR_WAIT -> next cycle `pc_addr` = RESET_PC, state FETCH, the late `branch_resolve` is ignored.
